// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: owner codes, arbiter states, default widths.
package data_mem_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P    = 2'd1,
    OWN_L    = 2'd2
  } owner_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCK_L = 1'b1
  } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_sat_counter.sv
// Saturating up-counter; clear with inc loads 1 so a new run can start in the same cycle.
module sat_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic iInc,
  input  logic iClr,
  output logic oSat
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (iClr) begin
      cnt <= iInc ? W'(1) : '0;
    end else if (iInc && !oSat) begin
      cnt <= cnt + W'(1);
    end
  end

  assign oSat = (cnt == W'(MAX));

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the MEM-stage data RAM between the pipeline (P) and the loader (L) with
// zero-latency grants, starvation relief for L, bounded L bursts and registered read return.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_MAX     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iReqP,
  input  logic              iWeP,
  input  logic [ADDR_W-1:0] iAddrP,
  input  logic [DATA_W-1:0] iDataP,
  output logic              oGntP,
  output logic              oStallP,
  output logic              oRdValidP,
  input  logic              iReqL,
  input  logic              iWeL,
  input  logic              iLockL,
  input  logic [ADDR_W-1:0] iAddrL,
  input  logic [DATA_W-1:0] iDataL,
  output logic              oGntL,
  output logic              oRdValidL,
  output logic              oRamWe,
  output logic [ADDR_W-1:0] oRamAddr,
  output logic [DATA_W-1:0] oRamData,
  input  logic [DATA_W-1:0] iRamData,
  output logic [DATA_W-1:0] oRdData
);

  localparam int unsigned STARVE_W = 4;
  localparam int unsigned LOCK_W   = 8;

  arb_state_t        state, stateNext;
  owner_t            rdOwner;
  logic              pPrio, pPrioNext;
  logic              forcedRel, lPrio;
  logic              gntP, gntL;
  logic              starveInc, starveSat;
  logic              lockInc, lockClr, lockSat;
  logic              rdP, rdL;
  logic [ADDR_W-1:0] lastAddr, ramAddr;
  logic [DATA_W-1:0] lastData, ramData, rdData;

  sat_counter #(.W(STARVE_W), .MAX(STARVE_LIMIT)) uStarveCnt (
    .clk  (clk),
    .rst  (rst),
    .iInc (starveInc),
    .iClr (!starveInc),
    .oSat (starveSat)
  );

  sat_counter #(.W(LOCK_W), .MAX(LOCK_MAX)) uLockCnt (
    .clk  (clk),
    .rst  (rst),
    .iInc (lockInc),
    .iClr (lockClr),
    .oSat (lockSat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      pPrio <= 1'b0;
    end else begin
      state <= stateNext;
      pPrio <= pPrioNext;
    end
  end

  // A burst that reached LOCK_MAX is arbitrated as idle this cycle, with P favoured.
  always_comb begin
    stateNext = state;
    pPrioNext = pPrio;
    forcedRel = 1'b0;
    lPrio     = 1'b0;
    gntP      = 1'b0;
    gntL      = 1'b0;
    lockInc   = 1'b0;
    lockClr   = 1'b0;
    if (state == ARB_LOCK_L && !lockSat) begin
      gntL    = iReqL;
      lockInc = 1'b1;
      if (!iLockL || !iReqL) begin
        stateNext = ARB_IDLE;
      end
    end else begin
      forcedRel = (state == ARB_LOCK_L);
      lPrio     = starveSat && !(pPrio || forcedRel);
      gntP      = iReqP && !(iReqL && lPrio);
      gntL      = iReqL && !gntP;
      stateNext = ARB_IDLE;
      if (iReqP && iReqL) begin
        pPrioNext = 1'b0;
      end else if (forcedRel) begin
        pPrioNext = 1'b1;
      end
      if (gntL && iLockL) begin
        stateNext = ARB_LOCK_L;
        lockClr   = 1'b1;
        lockInc   = 1'b1;
      end
    end
    if (rst) begin
      gntP = 1'b0;
      gntL = 1'b0;
    end
  end

  assign starveInc = iReqL && !gntL;

  // Address and data hold their last driven value when nobody owns the RAM.
  always_comb begin
    ramAddr = lastAddr;
    ramData = lastData;
    if (gntP) begin
      ramAddr = iAddrP;
      ramData = iDataP;
    end else if (gntL) begin
      ramAddr = iAddrL;
      ramData = iDataL;
    end
  end

  assign rdP = gntP && !iWeP;
  assign rdL = gntL && !iWeL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdOwner  <= OWN_NONE;
      rdData   <= '0;
      lastAddr <= '0;
      lastData <= '0;
    end else begin
      rdOwner <= OWN_NONE;
      if (rdP) begin
        rdOwner <= OWN_P;
      end else if (rdL) begin
        rdOwner <= OWN_L;
      end
      if (rdP || rdL) begin
        rdData <= iRamData;
      end
      if (gntP || gntL) begin
        lastAddr <= ramAddr;
        lastData <= ramData;
      end
    end
  end

  assign oGntP     = gntP;
  assign oGntL     = gntL;
  assign oStallP   = iReqP && !gntP;
  assign oRamWe    = (gntP && iWeP) || (gntL && iWeL);
  assign oRamAddr  = ramAddr;
  assign oRamData  = ramData;
  assign oRdValidP = (rdOwner == OWN_P);
  assign oRdValidL = (rdOwner == OWN_L);
  assign oRdData   = rdData;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, hand-written corner sequences and
// random traffic against a cycle-level reference model with its own shadow memory.
module tb_data_mem_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int STARVE_LIMIT = 4;
  localparam int LOCK_MAX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqP, weP, reqL, weL, lockL;
  logic [AW-1:0] addrP, addrL;
  logic [DW-1:0] dataP, dataL;
  logic          oGntP, oStallP, oRdValidP, oGntL, oRdValidL, oRamWe;
  logic [AW-1:0] oRamAddr;
  logic [DW-1:0] oRamData, iRamData, oRdData;

  logic [DW-1:0] ram    [0:1023];
  logic [DW-1:0] refMem [0:1023];

  int nTests = 0;
  int nFail  = 0;
  int lockRun = 0;

  // Reference model state
  int         mStarve, mLockCycles;
  bit         mLocked, mPPrio, mVP, mVL, mGP, mGL;
  logic [7:0] mRd;

  typedef struct {
    bit rp; bit wp; logic [9:0] ap; logic [7:0] dp;
    bit rl; bit wl; bit lk; logic [9:0] al; logic [7:0] dl;
    bit gP; bit gL; bit st; bit we; bit vP; bit vL; logic [7:0] rd;
  } vec_t;

  vec_t vt [14];

  data_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .iReqP(reqP), .iWeP(weP), .iAddrP(addrP), .iDataP(dataP),
    .oGntP(oGntP), .oStallP(oStallP), .oRdValidP(oRdValidP),
    .iReqL(reqL), .iWeL(weL), .iLockL(lockL), .iAddrL(addrL), .iDataL(dataL),
    .oGntL(oGntL), .oRdValidL(oRdValidL),
    .oRamWe(oRamWe), .oRamAddr(oRamAddr), .oRamData(oRamData),
    .iRamData(iRamData), .oRdData(oRdData)
  );

  always #5 clk = ~clk;

  assign iRamData = ram[oRamAddr];
  always @(posedge clk) if (oRamWe) ram[oRamAddr] <= oRamData;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mStarve = 0; mLockCycles = 0; mLocked = 0; mPPrio = 0;
    mVP = 0; mVL = 0; mRd = 8'h00; mGP = 0; mGL = 0;
  endtask

  task automatic modelComb();
    bit forced;
    forced = mLocked && (mLockCycles >= LOCK_MAX);
    mGP = 0;
    mGL = 0;
    if (rst) return;
    if (mLocked && !forced) begin
      mGL = reqL;
    end else if (reqP && reqL) begin
      mGL = (mStarve == STARVE_LIMIT) && !(mPPrio || forced);
      mGP = !mGL;
    end else begin
      mGP = reqP;
      mGL = reqL;
    end
  endtask

  task automatic modelEdge();
    bit forced;
    forced = mLocked && (mLockCycles >= LOCK_MAX);
    if (rst) begin
      modelReset();
      return;
    end
    if (mLocked && !forced) begin
      mLockCycles++;
      if (!lockL || !reqL) mLocked = 0;
    end else begin
      if (reqP && reqL) mPPrio = 0;
      else if (forced)  mPPrio = 1;
      mLocked = mGL && lockL;
      mLockCycles = 1;
    end
    if (reqL && !mGL) mStarve = (mStarve < STARVE_LIMIT) ? mStarve + 1 : mStarve;
    else              mStarve = 0;
    mVP = mGP && !weP;
    mVL = mGL && !weL;
    if (mVP) mRd = refMem[addrP];
    if (mVL) mRd = refMem[addrL];
    if (mGP && weP) refMem[addrP] = dataP;
    if (mGL && weL) refMem[addrL] = dataL;
  endtask

  task automatic drive(input bit rp, input bit wp, input int ap, input int dp,
                       input bit rl, input bit wl, input bit lk, input int al, input int dl);
    reqP = rp; weP = wp; addrP = 10'(ap); dataP = 8'(dp);
    reqL = rl; weL = wl; lockL = lk; addrL = 10'(al); dataL = 8'(dl);
    #3;
    modelComb();
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkAll(input string tag);
    chk({tag, "_gntP"},   32'(oGntP),     32'(mGP));
    chk({tag, "_gntL"},   32'(oGntL),     32'(mGL));
    chk({tag, "_stall"},  32'(oStallP),   32'(reqP && !mGP));
    chk({tag, "_we"},     32'(oRamWe),    32'((mGP && weP) || (mGL && weL)));
    chk({tag, "_vP"},     32'(oRdValidP), 32'(mVP));
    chk({tag, "_vL"},     32'(oRdValidL), 32'(mVL));
    chk({tag, "_rdData"}, 32'(oRdData),   32'(mRd));
    if (mGP || mGL) chk({tag, "_addr"}, 32'(oRamAddr), 32'(mGP ? addrP : addrL));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 8'(i * 7);
    end
    ram[10'h005] = 8'h3C;
    ram[10'h200] = 8'hA1;
    ram[10'h201] = 8'hB2;
    for (int i = 0; i < 1024; i++) refMem[i] = ram[i];

    vt[0]  = '{1,0,10'h005,8'h00, 0,0,0,10'h000,8'h00, 1,0,0,0,0,0,8'h00};
    vt[1]  = '{0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,0,0,0,1,0,8'h3C};
    vt[2]  = '{0,0,10'h000,8'h00, 1,0,0,10'h200,8'h00, 0,1,0,0,0,0,8'h3C};
    vt[3]  = '{1,0,10'h201,8'h00, 0,0,0,10'h000,8'h00, 1,0,0,0,0,1,8'hA1};
    vt[4]  = '{0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,0,0,0,1,0,8'hB2};
    vt[5]  = '{1,1,10'h010,8'h55, 0,0,0,10'h000,8'h00, 1,0,0,1,0,0,8'hB2};
    vt[6]  = '{0,0,10'h000,8'h00, 1,1,0,10'h300,8'h77, 0,1,0,1,0,0,8'hB2};
    vt[7]  = '{1,0,10'h010,8'h00, 0,0,0,10'h000,8'h00, 1,0,0,0,0,0,8'hB2};
    vt[8]  = '{0,0,10'h000,8'h00, 1,0,0,10'h300,8'h00, 0,1,0,0,1,0,8'h55};
    vt[9]  = '{1,0,10'h005,8'h00, 0,0,0,10'h000,8'h00, 1,0,0,0,0,1,8'h77};
    vt[10] = '{0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,0,0,0,1,0,8'h3C};
    vt[11] = '{0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,0,0,0,0,0,8'h3C};
    vt[12] = '{1,0,10'h005,8'h00, 1,0,0,10'h200,8'h00, 1,0,0,0,0,0,8'h3C};
    vt[13] = '{0,0,10'h000,8'h00, 0,0,0,10'h000,8'h00, 0,0,0,0,1,0,8'h3C};

    modelReset();
    reqP = 0; weP = 0; addrP = '0; dataP = '0;
    reqL = 0; weL = 0; lockL = 0; addrL = '0; dataL = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_gntP",   32'(oGntP),     32'(0));
    chk("rst_gntL",   32'(oGntL),     32'(0));
    chk("rst_we",     32'(oRamWe),    32'(0));
    chk("rst_vP",     32'(oRdValidP), 32'(0));
    chk("rst_vL",     32'(oRdValidL), 32'(0));
    chk("rst_rdData", 32'(oRdData),   32'(0));
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int r = 0; r < 14; r++) begin
      drive(vt[r].rp, vt[r].wp, int'(vt[r].ap), int'(vt[r].dp),
            vt[r].rl, vt[r].wl, vt[r].lk, int'(vt[r].al), int'(vt[r].dl));
      chk($sformatf("vec%0d_gntP", r),  32'(oGntP),     32'(vt[r].gP));
      chk($sformatf("vec%0d_gntL", r),  32'(oGntL),     32'(vt[r].gL));
      chk($sformatf("vec%0d_stall", r), 32'(oStallP),   32'(vt[r].st));
      chk($sformatf("vec%0d_we", r),    32'(oRamWe),    32'(vt[r].we));
      chk($sformatf("vec%0d_vP", r),    32'(oRdValidP), 32'(vt[r].vP));
      chk($sformatf("vec%0d_vL", r),    32'(oRdValidL), 32'(vt[r].vL));
      chk($sformatf("vec%0d_rd", r),    32'(oRdData),   32'(vt[r].rd));
      tick();
    end

    // Continuous contention: L forced in every fifth cycle
    for (int c = 0; c < 15; c++) begin
      drive(1, 0, 'h005, 0, 1, 0, 0, 'h200, 0);
      chk($sformatf("starve%0d_gntP", c),  32'(oGntP),   32'((c % 5) != 4));
      chk($sformatf("starve%0d_gntL", c),  32'(oGntL),   32'((c % 5) == 4));
      chk($sformatf("starve%0d_stall", c), 32'(oStallP), 32'((c % 5) == 4));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Locked L write burst, P joining from the second cycle; forced release after LOCK_MAX
    for (int i = 0; i <= LOCK_MAX; i++) begin
      drive(i > 0, 0, 'h005, 0, 1, 1, 1, 'h100 + ((i < 16) ? i : 15), 'hC0 + i);
      chk($sformatf("burst%0d_gntL", i),  32'(oGntL),   32'(i < LOCK_MAX));
      chk($sformatf("burst%0d_gntP", i),  32'(oGntP),   32'(i == LOCK_MAX));
      chk($sformatf("burst%0d_stall", i), 32'(oStallP), 32'(i > 0 && i < LOCK_MAX));
      tick();
    end
    drive(0, 0, 0, 0, 1, 0, 0, 'h10F, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 'h100, 0);
    chk("burst_rb_vL", 32'(oRdValidL), 32'(1));
    chk("burst_rb_10F", 32'(oRdData), 32'(8'hCF));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("burst_rb_100", 32'(oRdData), 32'(8'hC0));
    tick();

    // Reset arriving in the third cycle of an L burst
    drive(0, 0, 0, 0, 1, 0, 1, 'h200, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0, 1, 'h201, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 1, 'h202, 'h99);
    chk("rstmid_pre_gntL", 32'(oGntL),     32'(1));
    chk("rstmid_pre_we",   32'(oRamWe),    32'(1));
    chk("rstmid_pre_vL",   32'(oRdValidL), 32'(1));
    chk("rstmid_pre_rd",   32'(oRdData),   32'(8'hB2));
    rst = 1'b1;
    #1;
    modelReset();
    chk("rstmid_gntL", 32'(oGntL),     32'(0));
    chk("rstmid_gntP", 32'(oGntP),     32'(0));
    chk("rstmid_we",   32'(oRamWe),    32'(0));
    chk("rstmid_vL",   32'(oRdValidL), 32'(0));
    chk("rstmid_vP",   32'(oRdValidP), 32'(0));
    tick();
    rst = 1'b0;
    drive(1, 0, 'h005, 0, 0, 0, 0, 0, 0);
    chk("rstmid_post_gntP",  32'(oGntP),   32'(1));
    chk("rstmid_post_stall", 32'(oStallP), 32'(0));
    tick();
    drive(1, 0, 'h202, 0, 0, 0, 0, 0, 0);
    chk("rstmid_post_vP", 32'(oRdValidP), 32'(1));
    chk("rstmid_post_rd", 32'(oRdData),   32'(8'h3C));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rstmid_nowrite", 32'(oRdData), 32'(refMem[10'h202]));
    tick();

    // Random traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      bit rp, wp, rl, wl, lk;
      rp = ($urandom_range(0, 3) != 0);
      wp = ($urandom_range(0, 1) == 1);
      wl = ($urandom_range(0, 1) == 1);
      if (lockRun > 0) begin
        rl = 1; lk = 1; lockRun--;
      end else begin
        rl = ($urandom_range(0, 1) == 1);
        lk = 0;
        if ($urandom_range(0, 19) == 0) begin
          lockRun = int'($urandom_range(5, 24));
          rl = 1; lk = 1;
        end
      end
      drive(rp, wp, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            rl, wl, lk, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      checkAll($sformatf("rnd%0d", c));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
